huffman_bitpacker: RTL

//  Downstream neighbour of the Huffman code-table generator. Latches the six-entry code

---
 rtl/huffman_pkg.sv | 26 ++
 rtl/huffman_code_rom.sv | 48 ++++
 rtl/huffman_bitpacker.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/huffman_pkg.sv
// Shared types and constants for the Huffman bit packer.
// Holds the FSM state enum, symbol range constants and a popcount helper.
package huffman_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam int SYM_MIN = 1;
    localparam int SYM_MAX = 6;
    localparam int NUM_SYM = 6;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/huffman_code_rom.sv
// Latched six-entry code table with a combinational symbol lookup.
// Ports: clk, reset, i_load (latch i_hc/i_m), i_sym -> o_legal, o_len, o_code.
module huffman_code_rom
    import huffman_pkg::*;
#(
    parameter int MAX_LEN = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_load,
    input  logic [NUM_SYM-1:0][7:0]       i_hc,
    input  logic [NUM_SYM-1:0][7:0]       i_m,
    input  logic [7:0]                    i_sym,
    output logic                          o_legal,
    output logic [3:0]                    o_len,
    output logic [MAX_LEN-1:0]            o_code
);

    logic [NUM_SYM-1:0][MAX_LEN-1:0] r_code;
    logic [NUM_SYM-1:0][3:0]         r_len;

    // Codes are stored pre-masked so the packer can OR them in directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_code <= '0;
            r_len  <= '0;
        end else if (i_load) begin
            for (int k = 0; k < NUM_SYM; k++) begin
                r_code[k] <= MAX_LEN'(i_hc[k] & i_m[k]);
                r_len[k]  <= popcount8(i_m[k]);
            end
        end
    end

    always_comb begin
        o_legal = 1'b0;
        o_len   = '0;
        o_code  = '0;
        for (int k = 0; k < NUM_SYM; k++) begin
            if (i_sym == 8'(k + SYM_MIN)) begin
                o_legal = 1'b1;
                o_len   = r_len[k];
                o_code  = r_code[k];
            end
        end
    end

endmodule

// File: rtl/huffman_bitpacker.sv
// Encodes gray symbols 1..6 with a latched Huffman table and packs the codes MSB-first into bytes.
// Ports: code_valid/HCn/Mn table in, gray_* symbol stream in, out_* byte stream out, bit_total/frame_done/sym_err status.
module huffman_bitpacker
    import huffman_pkg::*;
#(
    parameter int ACC_W   = 16,
    parameter int MAX_LEN = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        code_valid,
    input  logic [7:0]  HC1,
    input  logic [7:0]  HC2,
    input  logic [7:0]  HC3,
    input  logic [7:0]  HC4,
    input  logic [7:0]  HC5,
    input  logic [7:0]  HC6,
    input  logic [7:0]  M1,
    input  logic [7:0]  M2,
    input  logic [7:0]  M3,
    input  logic [7:0]  M4,
    input  logic [7:0]  M5,
    input  logic [7:0]  M6,
    input  logic        gray_valid,
    input  logic [7:0]  gray_data,
    input  logic        gray_last,
    output logic        gray_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_last,
    input  logic        out_ready,
    output logic [15:0] bit_total,
    output logic        frame_done,
    output logic        sym_err
);

    localparam int CNT_W = $clog2(ACC_W + 1);
    localparam logic [CNT_W-1:0] BYTE = CNT_W'(8);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_cv_q;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_bitcnt;
    logic [15:0]        r_bit_total;
    logic               r_sym_err;

    logic               w_cv_rise;
    logic               w_accept;
    logic               w_emit;
    logic               w_legal;
    logic [3:0]         w_len;
    logic [MAX_LEN-1:0] w_code;
    logic [7:0]         w_byte;

    huffman_code_rom #(
        .MAX_LEN (MAX_LEN)
    ) u_rom (
        .clk     (clk),
        .reset   (reset),
        .i_load  (r_state == S_LOAD),
        .i_hc    ({HC6, HC5, HC4, HC3, HC2, HC1}),
        .i_m     ({M6, M5, M4, M3, M2, M1}),
        .i_sym   (gray_data),
        .o_legal (w_legal),
        .o_len   (w_len),
        .o_code  (w_code)
    );

    // Resetting the history to 1 means a level already high out of
    // reset is not seen as a rising edge.
    assign w_cv_rise = code_valid & ~r_cv_q;
    assign w_accept  = gray_valid & gray_ready;
    assign w_emit    = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_cv_rise) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_RUN;
            S_RUN:   if (w_accept && gray_last) w_state_nxt = S_FLUSH;
            S_FLUSH: begin
                if (r_bitcnt == '0)          w_state_nxt = S_DONE;
                else if (w_emit && out_last) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Whole bytes come from the top of the live bits; a short tail is
    // left-aligned so the pad zeros land in the low bits.
    always_comb begin
        if (r_bitcnt >= BYTE) w_byte = 8'(r_acc >> (r_bitcnt - BYTE));
        else                  w_byte = 8'(r_acc << (BYTE - r_bitcnt));
    end

    always_comb begin
        gray_ready = (r_state == S_RUN) && (r_bitcnt < BYTE);
        out_valid  = ((r_state == S_RUN) && (r_bitcnt >= BYTE)) ||
                     ((r_state == S_FLUSH) && (r_bitcnt != '0));
        out_last   = (r_state == S_FLUSH) && (r_bitcnt != '0) &&
                     (r_bitcnt <= BYTE);
        out_data   = out_valid ? w_byte : 8'h00;
        frame_done = (r_state == S_DONE);
        bit_total  = r_bit_total;
        sym_err    = r_sym_err;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cv_q      <= 1'b1;
            r_acc       <= '0;
            r_bitcnt    <= '0;
            r_bit_total <= '0;
            r_sym_err   <= 1'b0;
        end else begin
            r_cv_q <= code_valid;
            unique case (r_state)
                S_LOAD: begin
                    r_acc       <= '0;
                    r_bitcnt    <= '0;
                    r_bit_total <= '0;
                    r_sym_err   <= 1'b0;
                end
                S_RUN: begin
                    if (w_accept) begin
                        if (w_legal) begin
                            r_acc       <= (r_acc << w_len) | ACC_W'(w_code);
                            r_bitcnt    <= r_bitcnt + CNT_W'(w_len);
                            r_bit_total <= r_bit_total + 16'(w_len);
                        end else begin
                            r_sym_err <= 1'b1;
                        end
                    end
                    if (w_emit) r_bitcnt <= r_bitcnt - BYTE;
                end
                S_FLUSH: begin
                    if (w_emit) r_bitcnt <= out_last ? '0 : r_bitcnt - BYTE;
                end
                default: ;
            endcase
        end
    end

endmodule
